hazard_ctrl: RTL



---
 rtl/hazard_ctrl_pkg.sv | 14 +
 rtl/hazard_ctrl_if.sv | 38 +++
 rtl/hazard_ctrl_sat_counter.sv | 22 ++
 rtl/hazard_ctrl.sv | 116 +++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the memory-wait FSM encoding and the NOP instruction word.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } hz_state_e;

    // addi x0, x0, 0 -- what a squashed pipeline register decodes as
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller.
// master: datapath side (drives hazard inputs); slave: controller side.
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       IFID_rs1;
    logic [4:0]       IFID_rs2;
    logic             IFID_use_rs2;
    logic [4:0]       IDEX_rd;
    logic             IDEX_MemRead;
    logic             EX_redirect;
    logic             dmem_req;
    logic             dmem_ready;
    logic             pc_stall;
    logic             IFID_stall;
    logic             IFID_flush;
    logic             IDEX_stall;
    logic             IDEX_flush;
    logic             EXMEM_stall;
    logic             MEMWB_bubble;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output IFID_rs1, IFID_rs2, IFID_use_rs2, IDEX_rd, IDEX_MemRead,
        output EX_redirect, dmem_req, dmem_ready,
        input  pc_stall, IFID_stall, IFID_flush, IDEX_stall, IDEX_flush,
        input  EXMEM_stall, MEMWB_bubble, mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  IFID_rs1, IFID_rs2, IFID_use_rs2, IDEX_rd, IDEX_MemRead,
        input  EX_redirect, dmem_req, dmem_ready,
        output pc_stall, IFID_stall, IFID_flush, IDEX_stall, IDEX_flush,
        output EXMEM_stall, MEMWB_bubble, mem_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
// Ports: clk, rst (sync active-high), inc (count enable), count (value).
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);
    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/bubble sequencing for the 5-stage pipeline: load-use,
// EX redirects and data-memory waits with timeout watchdog.
// Ports: clk, rst (sync active-high), hz (hazard_ctrl_if slave bundle).
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz
);
    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

    hz_state_e       state_q, state_d;
    logic [WC_W-1:0] wcnt_q, wcnt_d;
    logic            err_q, err_d;

    logic mem_wait;
    logic load_use;
    logic freeze;
    logic redir;
    logic lu_stall;

    assign mem_wait = hz.dmem_req & ~hz.dmem_ready;

    assign load_use = hz.IDEX_MemRead & (hz.IDEX_rd != 5'd0) &
                      ((hz.IDEX_rd == hz.IFID_rs1) |
                       (hz.IFID_use_rs2 & (hz.IDEX_rd == hz.IFID_rs2)));

    // One-hot priority: freeze > redirect > load-use; all masked by rst
    always_comb begin
        freeze   = 1'b0;
        redir    = 1'b0;
        lu_stall = 1'b0;
        if (!rst) begin
            if ((state_q == ERR) || mem_wait) begin
                freeze = 1'b1;
            end else if (hz.EX_redirect) begin
                redir = 1'b1;
            end else if (load_use) begin
                lu_stall = 1'b1;
            end
        end
    end

    assign hz.pc_stall     = freeze | lu_stall;
    assign hz.IFID_stall   = freeze | lu_stall;
    assign hz.IFID_flush   = redir;
    assign hz.IDEX_stall   = freeze;
    assign hz.IDEX_flush   = redir | lu_stall;
    assign hz.EXMEM_stall  = freeze;
    assign hz.MEMWB_bubble = freeze;
    assign hz.mem_err      = err_q;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        err_d   = err_q;
        unique case (state_q)
            RUN: begin
                if (mem_wait) begin
                    state_d = MEM_WAIT;
                    wcnt_d  = WC_W'(1);
                end
            end
            MEM_WAIT: begin
                // Ready or a dropped request both end the wait
                if (!mem_wait) begin
                    state_d = RUN;
                    wcnt_d  = '0;
                end else if (wcnt_q == WC_LAST) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = RUN;
                wcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (hz.pc_stall),
        .count (hz.stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (redir),
        .count (hz.flush_cnt)
    );
endmodule
